// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Step counter width: clog2(steps), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    int unsigned w;
    w = (steps <= 2) ? 1 : $clog2(steps);
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full-adder cell, chained DIGIT times inside serial_adder.
module fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock through a ripple chain and a carry flop,
// with a start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);

  localparam int unsigned DigDiv = (DIGIT == 0) ? 1 : DIGIT;
  localparam int unsigned STEPS  = WIDTH / DigDiv;
  localparam int unsigned CntW   = cnt_width(STEPS);

  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DigDiv) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT, with 1 <= DIGIT <= WIDTH");
  end

  state_e            r_state, w_state_d;
  logic [WIDTH-1:0]  r_a, r_b, r_sum_sh, r_sum;
  logic              r_carry, r_cout, r_ovf;
  logic [CntW-1:0]   r_cnt;
  logic [DIGIT:0]    w_c;
  logic [DIGIT-1:0]  w_digit;
  logic [WIDTH-1:0]  w_sum_next;
  logic              w_last;

  assign w_c[0] = r_carry;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_chain
    fa_cell u_fa (
      .i_a  (r_a[gi]),
      .i_b  (r_b[gi]),
      .i_ci (w_c[gi]),
      .o_s  (w_digit[gi]),
      .o_co (w_c[gi+1])
    );
  end

  // New digit enters from the MSB side so the result is LSB-aligned after STEPS shifts.
  assign w_sum_next = (r_sum_sh >> DIGIT) | (WIDTH'(w_digit) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CntW'(STEPS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == StIdle && i_start) begin
      r_a      <= i_a;
      r_b      <= i_b;
      r_carry  <= i_cin;
      r_cnt    <= '0;
      r_sum_sh <= '0;
    end else if (r_state == StRun) begin
      r_a      <= r_a >> DIGIT;
      r_b      <= r_b >> DIGIT;
      r_carry  <= w_c[DIGIT];
      r_sum_sh <= w_sum_next;
      r_cnt    <= r_cnt + CntW'(1);
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_c[DIGIT];
        r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
      end
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit (DIGIT 1 and 4) scenarios and a 4-bit exhaustive sweep.
module tb_serial_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res8_t;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } res4_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start81, start84, start4;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [3:0] a4, b4;
  logic       cin4;

  logic       busy81, done81, cout81, ovf81;
  logic [7:0] sum81;
  logic       busy84, done84, cout84, ovf84;
  logic [7:0] sum84;
  logic       busy4 [3];
  logic       done4 [3];
  logic       cout4 [3];
  logic       ovf4  [3];
  logic [3:0] sum4  [3];

  int n_cmp = 0;
  int n_bad = 0;

  res8_t q81[$];
  res8_t q84[$];
  res4_t q41[$];
  res4_t q42[$];
  res4_t q44[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut81 (
    .i_clk(clk), .i_rst(rst), .i_start(start81), .i_a(a8), .i_b(b8), .i_cin(cin8),
    .o_busy(busy81), .o_done(done81), .o_sum(sum81), .o_cout(cout81), .o_overflow(ovf81)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut84 (
    .i_clk(clk), .i_rst(rst), .i_start(start84), .i_a(a8), .i_b(b8), .i_cin(cin8),
    .o_busy(busy84), .o_done(done84), .o_sum(sum84), .o_cout(cout84), .o_overflow(ovf84)
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut41 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a4), .i_b(b4), .i_cin(cin4),
    .o_busy(busy4[0]), .o_done(done4[0]), .o_sum(sum4[0]), .o_cout(cout4[0]),
    .o_overflow(ovf4[0])
  );

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut42 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a4), .i_b(b4), .i_cin(cin4),
    .o_busy(busy4[1]), .o_done(done4[1]), .o_sum(sum4[1]), .o_cout(cout4[1]),
    .o_overflow(ovf4[1])
  );

  serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut44 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a4), .i_b(b4), .i_cin(cin4),
    .o_busy(busy4[2]), .o_done(done4[2]), .o_sum(sum4[2]), .o_cout(cout4[2]),
    .o_overflow(ovf4[2])
  );

  function automatic res8_t model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    res8_t      r;
    logic [8:0] s;
    s      = {1'b0, a} + {1'b0, b} + {8'b0, c};
    r.sum  = s[7:0];
    r.cout = s[8];
    r.ovf  = (a[7] == b[7]) && (s[7] != a[7]);
    return r;
  endfunction

  function automatic res4_t model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    res4_t      r;
    logic [4:0] s;
    s      = {1'b0, a} + {1'b0, b} + {4'b0, c};
    r.sum  = s[3:0];
    r.cout = s[4];
    r.ovf  = (a[3] == b[3]) && (s[3] != a[3]);
    return r;
  endfunction

  // Presents one operation to the DIGIT=1 instance; returns just after the accepting edge.
  task automatic drive81(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start81 = 1'b1;
    q81.push_back(model8(a, b, c));
    @(posedge clk);
    #1 start81 = 1'b0;
  endtask

  // Waits for done on the DIGIT=1 instance and checks result and latency; ends on the done sample.
  task automatic collect81(input string nm, output int lat, output int nbusy);
    bit    seen;
    res8_t e;
    seen = 0; lat = 0; nbusy = 0;
    @(negedge clk);
    if (busy81) nbusy++;
    while (!seen && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (busy81) nbusy++;
      if (done81) seen = 1;
    end
    e = (q81.size() > 0) ? q81.pop_front() : '0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles, required done after 8", nm, lat);
    end else begin
      n_cmp++;
      if ({sum81, cout81, ovf81} !== e) begin
        n_bad++;
        $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 nm, sum81, cout81, ovf81, e.sum, e.cout, e.ovf);
      end
      if (lat != 8) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d cycles, required 8", nm, lat);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start81 = 0; start84 = 0; start4 = 0;
    a8 = '0; b8 = '0; cin8 = 0; a4 = '0; b4 = '0; cin4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy81, done81, sum81, cout81, ovf81} !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_81: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy81, done81, sum81, cout81, ovf81);
    end
    n_cmp++;
    if ({busy84, done84, sum84, cout84, ovf84} !== 12'b0) begin
      n_bad++;
      $display("FAIL reset_84: got busy=%b done=%b sum=%h, required all 0", busy84, done84, sum84);
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({busy4[d], done4[d], sum4[d], cout4[d], ovf4[d]} !== 8'b0) begin
        n_bad++;
        $display("FAIL reset_4bit_%0d: got busy=%b done=%b sum=%h, required all 0",
                 d, busy4[d], done4[d], sum4[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int lat, nb;
    drive81(8'h00, 8'h00, 1'b0);
    collect81("zero", lat, nb);
    n_cmp++;
    if (nb != 9) begin
      n_bad++;
      $display("FAIL zero_busy_cycles: got %0d, required 9", nb);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (done81 !== 1'b0 || busy81 !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_done_pulse: got done=%b busy=%b after DONE, required 0 0",
               done81, busy81);
    end
  endtask

  task automatic test_corners;
    logic [7:0] av [3];
    logic [7:0] bv [3];
    int lat, nb;
    av = '{8'hFF, 8'h7F, 8'h80};
    bv = '{8'h01, 8'h01, 8'h80};
    for (int i = 0; i < 3; i++) begin
      drive81(av[i], bv[i], 1'b0);
      collect81($sformatf("corner%0d", i), lat, nb);
    end
  endtask

  task automatic test_digit4;
    int    lat;
    bit    seen;
    res8_t e;
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1; start84 = 1'b1;
    q84.push_back(model8(8'hA5, 8'h5A, 1'b1));
    @(posedge clk);
    #1 start84 = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 10) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done84) seen = 1;
    end
    e = q84.pop_front();
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL digit4_timeout: no done within %0d cycles, required after 2", lat);
    end else begin
      n_cmp++;
      if ({sum84, cout84, ovf84} !== e) begin
        n_bad++;
        $display("FAIL digit4_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                 sum84, cout84, ovf84, e.sum, e.cout, e.ovf);
      end
      if (lat != 2) begin
        n_bad++;
        $display("FAIL digit4_latency: got %0d cycles, required 2", lat);
      end
    end
  endtask

  task automatic test_ignore_start;
    int    ndone, done_lat;
    res8_t e;
    ndone = 0; done_lat = 0;
    drive81(8'h12, 8'h34, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1 start81 = 1'b0;
      if (k == 3) begin
        a8 = 8'hFF; b8 = 8'hFF; start81 = 1'b1;
      end
      @(negedge clk);
      if (done81) begin
        ndone++;
        if (done_lat == 0) begin
          done_lat = k;
          e = q81.pop_front();
          n_cmp++;
          if ({sum81, cout81, ovf81} !== e) begin
            n_bad++;
            $display("FAIL ignore_result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     sum81, cout81, ovf81, e.sum, e.cout, e.ovf);
          end
          a8 = 8'hFF; b8 = 8'hFF; start81 = 1'b1;
        end
      end
    end
    start81 = 1'b0;
    n_cmp++;
    if (ndone != 1 || done_lat != 8) begin
      n_bad++;
      $display("FAIL ignore_done_count: got %0d pulses (first at %0d), required 1 at 8",
               ndone, done_lat);
    end
    n_cmp++;
    if (sum81 !== 8'h46 || busy81 !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_final: got sum=%h busy=%b, required sum=46 busy=0", sum81, busy81);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    drive81(8'h21, 8'h43, 1'b1);
    collect81("b2b_first", lat, nb);
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy81 !== 1'b0 || done81 !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_idle: got busy=%b done=%b after DONE, required 0 0", busy81, done81);
    end
    a8 = 8'h10; b8 = 8'h0F; cin8 = 1'b0; start81 = 1'b1;
    q81.push_back(model8(8'h10, 8'h0F, 1'b0));
    @(posedge clk);
    #1 start81 = 1'b0;
    collect81("b2b_second", lat, nb);
  endtask

  task automatic test_reset_mid;
    int lat, nb;
    bit saw_done;
    drive81(8'h7F, 8'h01, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(q81.pop_back());
    @(negedge clk);
    n_cmp++;
    if ({busy81, done81, sum81, cout81, ovf81} !== 12'b0) begin
      n_bad++;
      $display("FAIL midreset_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
               busy81, done81, sum81, cout81, ovf81);
    end
    saw_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done81) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_bad++;
      $display("FAIL midreset_no_done: got a done pulse, required none");
    end
    drive81(8'h03, 8'h04, 1'b0);
    collect81("after_reset", lat, nb);
  endtask

  task automatic test_sweep4;
    int    steps [3];
    res4_t prev  [3];
    bit    got   [3];
    res4_t e;
    int    lat;
    steps = '{4, 2, 1};
    prev  = '{default: '0};
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          q41.push_back(model4(4'(ia), 4'(ib), 1'(ic)));
          q42.push_back(model4(4'(ia), 4'(ib), 1'(ic)));
          q44.push_back(model4(4'(ia), 4'(ib), 1'(ic)));
          @(posedge clk);
          #1 start4 = 1'b0;
          got = '{default: 1'b0};
          lat = 0;
          while (!(got[0] && got[1] && got[2]) && lat < 10) begin
            @(posedge clk); lat++;
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
              if (!got[d]) begin
                n_cmp++;
                if (done4[d]) begin
                  got[d] = 1;
                  case (d)
                    0:       e = q41.pop_front();
                    1:       e = q42.pop_front();
                    default: e = q44.pop_front();
                  endcase
                  if ({sum4[d], cout4[d], ovf4[d]} !== e || lat != steps[d]) begin
                    n_bad++;
                    $display("FAIL sweep_d%0d a=%h b=%h c=%0d: got sum=%h cout=%b ovf=%b lat=%0d, required sum=%h cout=%b ovf=%b lat=%0d",
                             steps[d] == 4 ? 1 : (steps[d] == 2 ? 2 : 4), ia, ib, ic,
                             sum4[d], cout4[d], ovf4[d], lat, e.sum, e.cout, e.ovf, steps[d]);
                  end
                  prev[d] = e;
                end else if ({sum4[d], cout4[d], ovf4[d]} !== prev[d]) begin
                  n_bad++;
                  $display("FAIL sweep_stable_%0d a=%h b=%h c=%0d: got %h during RUN, required %h",
                           d, ia, ib, ic, {sum4[d], cout4[d], ovf4[d]}, prev[d]);
                end
              end
            end
          end
          for (int d = 0; d < 3; d++) begin
            if (!got[d]) begin
              n_cmp++;
              n_bad++;
              $display("FAIL sweep_timeout_%0d a=%h b=%h c=%0d: no done, required done", d, ia, ib, ic);
              case (d)
                0:       void'(q41.pop_front());
                1:       void'(q42.pop_front());
                default: void'(q44.pop_front());
              endcase
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_corners();
    test_digit4();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
